// File: rtl/op2_loader.sv
// ---------------------------------------------------------------------------
// op2_loader
// Serial-to-parallel front end for the op2 16-input adder stage.
// Samples arrive one per cycle over a valid/ready handshake and are packed
// into a 16-slot register bank. When the bank is full, the frame is shown in
// parallel and held until the consumer acknowledges it.
//
// Ports
//   clock                    in   rising-edge clock
//   reset                    in   asynchronous active-low reset
//   in_data[DATA_WIDTH]      in   incoming sample
//   in_valid                 in   in_data valid this cycle
//   in_ready                 out  block accepts a sample this cycle (FILL)
//   clear                    in   synchronous frame abort (slots kept)
//   data0_out..data15_out    out  packed frame, slot k = k-th accepted sample
//   out_valid                out  frame complete and stable
//   out_ack                  in   consumer has taken the frame
//   count[5]                 out  samples held in the current frame (0..16)
// ---------------------------------------------------------------------------
module op2_loader #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data0_out,
    output logic [DATA_WIDTH-1:0] data1_out,
    output logic [DATA_WIDTH-1:0] data2_out,
    output logic [DATA_WIDTH-1:0] data3_out,
    output logic [DATA_WIDTH-1:0] data4_out,
    output logic [DATA_WIDTH-1:0] data5_out,
    output logic [DATA_WIDTH-1:0] data6_out,
    output logic [DATA_WIDTH-1:0] data7_out,
    output logic [DATA_WIDTH-1:0] data8_out,
    output logic [DATA_WIDTH-1:0] data9_out,
    output logic [DATA_WIDTH-1:0] data10_out,
    output logic [DATA_WIDTH-1:0] data11_out,
    output logic [DATA_WIDTH-1:0] data12_out,
    output logic [DATA_WIDTH-1:0] data13_out,
    output logic [DATA_WIDTH-1:0] data14_out,
    output logic [DATA_WIDTH-1:0] data15_out,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [4:0]            count
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t                r_state;
    logic [4:0]            r_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_slot [16];
    logic                  w_in_ready;

    // Ready is a pure decode of the state so it never depends on in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == ST_FILL) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = 1'b0;
        end
    end

    // Frame FSM: slot writes, sample count and frame-valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_FILL;
            r_count     <= 5'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_slot[i] <= '0;
            end
        end else if (clear) begin
            // Abort wins over a coincident handshake; that sample is dropped
            // and the slots keep whatever they held.
            r_state     <= ST_FILL;
            r_count     <= 5'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (in_valid) begin
                        // In FILL r_count is 0..15, so the low 4 bits index the slot.
                        r_slot[r_count[3:0]] <= in_data;
                        if (r_count == 5'd15) begin
                            r_count     <= 5'd16;
                            r_state     <= ST_FULL;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_count <= r_count + 5'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (out_ack) begin
                        r_state     <= ST_FILL;
                        r_count     <= 5'd0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_FILL;
                    r_count     <= 5'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign count      = r_count;
    assign data0_out  = r_slot[0];
    assign data1_out  = r_slot[1];
    assign data2_out  = r_slot[2];
    assign data3_out  = r_slot[3];
    assign data4_out  = r_slot[4];
    assign data5_out  = r_slot[5];
    assign data6_out  = r_slot[6];
    assign data7_out  = r_slot[7];
    assign data8_out  = r_slot[8];
    assign data9_out  = r_slot[9];
    assign data10_out = r_slot[10];
    assign data11_out = r_slot[11];
    assign data12_out = r_slot[12];
    assign data13_out = r_slot[13];
    assign data14_out = r_slot[14];
    assign data15_out = r_slot[15];

endmodule

// File: tb/tb_op2_loader.sv
// ---------------------------------------------------------------------------
// tb_op2_loader
// Directed and randomized stimulus for op2_loader, checked against a
// frame-level reference model (list of accepted samples, fill level, full flag).
// ---------------------------------------------------------------------------
module tb_op2_loader;

    localparam int DW = 12;

    logic          clock;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          clear;
    logic [DW-1:0] d [16];
    logic          out_valid;
    logic          out_ack;
    logic [4:0]    count;

    int checks;
    int passed;

    // Reference model state
    int          m_mem [16];
    int          m_cnt;
    bit          m_full;

    op2_loader #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clear(clear),
        .data0_out(d[0]),   .data1_out(d[1]),   .data2_out(d[2]),   .data3_out(d[3]),
        .data4_out(d[4]),   .data5_out(d[5]),   .data6_out(d[6]),   .data7_out(d[7]),
        .data8_out(d[8]),   .data9_out(d[9]),   .data10_out(d[10]), .data11_out(d[11]),
        .data12_out(d[12]), .data13_out(d[13]), .data14_out(d[14]), .data15_out(d[15]),
        .out_valid(out_valid), .out_ack(out_ack), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int dut_sum();
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(d[i]);
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    // Applies the block's frame rules to the inputs seen at one rising edge.
    task automatic model_edge();
        if (clear) begin
            m_cnt  = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (out_ack) begin
                m_full = 1'b0;
                m_cnt  = 0;
            end
        end else if (in_valid) begin
            m_mem[m_cnt] = int'(in_data);
            m_cnt++;
            if (m_cnt == 16) m_full = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, int'(count), m_cnt);
        chk({tag, ".out_valid"}, int'(out_valid), int'(m_full));
        chk({tag, ".in_ready"}, int'(in_ready), int'(!m_full));
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s.slot%0d", tag, i), int'(d[i]), m_mem[i]);
    endtask

    // One clock: inputs are already set; update model at the edge, check at negedge.
    task automatic step(input bit v, input int data, input bit ack, input bit clr, input string tag);
        in_valid = v;
        in_data  = DW'(data);
        out_ack  = ack;
        clear    = clr;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        int n;
        int hi_cnt;
        int rise_t [$];
        bit prev_ov;

        checks   = 0;
        passed   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ack  = 1'b0;
        clear    = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b1;

        // Reset then fill 0..15
        for (int k = 0; k < 16; k++) step(1'b1, k, 1'b0, 1'b0, "fill");
        chk("fill.out_valid", int'(out_valid), 1);
        chk("fill.count16", int'(count), 16);
        for (int k = 0; k < 16; k++) chk($sformatf("fill.data%0d", k), int'(d[k]), k);
        chk("fill.op2_sum", dut_sum(), 120);

        // Backpressure: valid held with 7 during FULL, then ack
        for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0, 1'b0, "bp.hold");
        step(1'b1, 7, 1'b1, 1'b0, "bp.ack");
        chk("bp.ready_after_ack", int'(in_ready), 1);
        step(1'b1, 7, 1'b0, 1'b0, "bp.first");
        chk("bp.slot0_is_7", int'(d[0]), 7);
        for (int i = 1; i < 16; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0, "bp.rest");
        step(1'b0, 0, 1'b1, 1'b0, "bp.ack2");

        // Sparse input: 4095 on every other cycle
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step((i % 2) == 0, 4095, 1'b0, 1'b0, "sparse");
            n++;
            if (out_valid) break;
        end
        chk("sparse.cycles", n, 31);
        chk("sparse.op2_sum", dut_sum(), 65520);
        step(1'b0, 0, 1'b1, 1'b0, "sparse.ack");

        // Clear mid-frame
        for (int i = 0; i < 7; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0, "clr.pre");
        chk("clr.count7", int'(count), 7);
        step(1'b0, 0, 1'b0, 1'b1, "clr.pulse");
        chk("clr.count0", int'(count), 0);
        for (int i = 0; i < 16; i++) step(1'b1, 3, 1'b0, 1'b0, "clr.fill3");
        chk("clr.sum48", dut_sum(), 48);
        step(1'b0, 0, 1'b1, 1'b0, "clr.ack");
        for (int i = 0; i < 15; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0, "clr.fill15");
        step(1'b1, 99, 1'b0, 1'b1, "clr.coincident");
        chk("clr.coinc_ov", int'(out_valid), 0);
        chk("clr.coinc_cnt", int'(count), 0);

        // Async reset mid-frame, between edges
        for (int i = 0; i < 10; i++) step(1'b1, int'($urandom_range(1, 4095)), 1'b0, 1'b0, "ares.pre");
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("ares.during");
        #1 reset = 1'b1;
        for (int k = 0; k < 16; k++) step(1'b1, k, 1'b0, 1'b0, "ares.refill");
        chk("ares.sum120", dut_sum(), 120);
        step(1'b0, 0, 1'b1, 1'b0, "ares.ack");

        // Continuous ack: three back-to-back frames
        hi_cnt  = 0;
        prev_ov = 1'b0;
        for (int t = 0; t < 51; t++) begin
            step(1'b1, int'($urandom_range(0, 4095)), 1'b1, 1'b0, "cont");
            if (out_valid) hi_cnt++;
            if (out_valid && !prev_ov) rise_t.push_back(t);
            prev_ov = out_valid;
        end
        chk("cont.high_cycles", hi_cnt, 3);
        chk("cont.frames", rise_t.size(), 3);
        if (rise_t.size() == 3) begin
            chk("cont.period1", rise_t[1] - rise_t[0], 17);
            chk("cont.period2", rise_t[2] - rise_t[1], 17);
        end

        // Random mix against the model
        for (int t = 0; t < 300; t++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Watchdog: the bench must always end by itself.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
